// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// dmem_arbiter_pkg : shared state and owner encodings for the data-memory arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        S_CPU  = 1'b0,
        S_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
// ============================================================================
// starve_counter : saturating, clearable up-counter flagging when LIMIT is reached
// Revision: 1.0
// ============================================================================
`default_nettype none

module starve_counter #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          at_limit
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign at_limit = (cnt_q == CW'(LIMIT));
    assign count    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares the single-port data memory between the CPU MEM stage
//                and a debug/loader port (CPU priority, starvation slot, lock)
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DW           = 16,
    parameter int unsigned AW           = 16,
    parameter int unsigned MEM_DEPTH    = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = cnt_width(STARVE_LIMIT);

    arb_state_e    state_q;
    arb_state_e    state_d;
    owner_e        owner;
    logic [CW-1:0] starve_cnt;
    logic          at_limit;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          dbg_in_range;
    logic          dbg_rvalid_q;
    logic          dbg_rvalid_d;
    logic          dbg_err_q;
    logic          dbg_err_d;
    logic [DW-1:0] dbg_rdata_q;

    assign dbg_in_range = ({1'b0, dbg_addr} < (AW + 1)'(MEM_DEPTH));

    always_comb begin
        owner   = OWN_NONE;
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (rst) begin
            if (state_q == S_LOCK) begin
                if (dbg_req) begin
                    owner = OWN_DBG;
                end
                // Lock release is sampled at the edge; this cycle stays debug-owned.
                if (!dbg_lock) begin
                    state_d = S_CPU;
                end
            end else begin
                if (dbg_req && (!cpu_req || at_limit)) begin
                    owner = OWN_DBG;
                end else if (cpu_req) begin
                    owner = OWN_CPU;
                end
                if (owner == OWN_DBG && dbg_lock) begin
                    state_d = S_LOCK;
                end
                cnt_inc = dbg_req && (owner != OWN_DBG);
                cnt_clr = !dbg_req || (owner == OWN_DBG);
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        cpu_rdata = '0;
        case (owner)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
                cpu_rdata = mem_rdata;
            end
            OWN_DBG: begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_we    = dbg_we && dbg_in_range;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign dbg_gnt      = (owner == OWN_DBG);
    assign cpu_stall    = rst && cpu_req && (owner != OWN_CPU);
    assign dbg_rvalid_d = dbg_gnt && !dbg_we && dbg_in_range;
    assign dbg_err_d    = dbg_gnt && !dbg_in_range;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_CPU;
            dbg_rvalid_q <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_err_q    <= dbg_err_d;
            if (dbg_rvalid_d) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_err    = dbg_err_q;
    assign dbg_rdata  = dbg_rdata_q;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CW    (CW)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .count    (starve_cnt),
        .at_limit (at_limit)
    );

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed self-checking bench for dmem_arbiter with a 64-word memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [15:0] mem [0:63];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_we && mem_addr < 16'd64) mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0;

        // Reset state and forced combinational outputs
        tick(); tick();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'd9; cpu_wdata = 16'hFFFF;
        dbg_req = 1; dbg_addr = 16'd9;
        settle();
        check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_err", 32'(dbg_err), 32'd0);
        check("rst_rdata", 32'(dbg_rdata), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(S_CPU));
        check("rst_cnt", 32'(dut.starve_cnt), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_gnt", 32'(dbg_gnt), 32'd0);
        tick();
        check("rst_no_write", 32'(mem[9]), 32'h1009);

        // CPU store then load
        rst = 1; dbg_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'd5; cpu_wdata = 16'h1234;
        settle();
        check("cpu_st_stall", 32'(cpu_stall), 32'd0);
        check("cpu_st_we", 32'(mem_we), 32'd1);
        tick();
        cpu_we = 0;
        settle();
        check("cpu_ld_stall", 32'(cpu_stall), 32'd0);
        check("cpu_ld_data", 32'(cpu_rdata), 32'h1234);
        tick();

        // Starvation: debug denied four cycles, wins the fifth
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'd3;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'd7;
        settle();
        for (int c = 0; c < 4; c++) begin
            check("starve_deny_gnt", 32'(dbg_gnt), 32'd0);
            check("starve_deny_stall", 32'(cpu_stall), 32'd0);
            tick();
        end
        check("starve_gnt", 32'(dbg_gnt), 32'd1);
        check("starve_stall", 32'(cpu_stall), 32'd1);
        check("starve_cpu_rdata", 32'(cpu_rdata), 32'd0);
        tick();
        dbg_req = 0;
        settle();
        check("starve_rvalid", 32'(dbg_rvalid), 32'd1);
        check("starve_rdata", 32'(dbg_rdata), 32'h1007);
        check("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        check("starve_cpu_back", 32'(cpu_stall), 32'd0);
        tick();
        check("starve_rvalid_pulse", 32'(dbg_rvalid), 32'd0);

        // Lock burst entered through the starvation slot
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'd10;
        dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 16'd10; dbg_wdata = 16'hAAAA;
        settle();
        for (int c = 0; c < 4; c++) begin
            check("lock_wait_gnt", 32'(dbg_gnt), 32'd0);
            tick();
        end
        check("lock_w0_gnt", 32'(dbg_gnt), 32'd1);
        check("lock_w0_stall", 32'(cpu_stall), 32'd1);
        check("lock_w0_we", 32'(mem_we), 32'd1);
        tick();
        dbg_addr = 16'd11; dbg_wdata = 16'hBBBB;
        settle();
        check("lock_state", 32'(dut.state_q), 32'(S_LOCK));
        check("lock_w1_gnt", 32'(dbg_gnt), 32'd1);
        check("lock_w1_stall", 32'(cpu_stall), 32'd1);
        tick();
        dbg_addr = 16'd12; dbg_wdata = 16'hCCCC; dbg_lock = 0;
        settle();
        check("lock_w2_gnt", 32'(dbg_gnt), 32'd1);
        check("lock_w2_stall", 32'(cpu_stall), 32'd1);
        tick();
        dbg_req = 0; dbg_we = 0;
        settle();
        check("unlock_state", 32'(dut.state_q), 32'(S_CPU));
        check("unlock_stall", 32'(cpu_stall), 32'd0);
        check("unlock_ld10", 32'(cpu_rdata), 32'hAAAA);
        tick();
        cpu_addr = 16'd11;
        settle();
        check("unlock_ld11", 32'(cpu_rdata), 32'hBBBB);
        tick();
        cpu_addr = 16'd12;
        settle();
        check("unlock_ld12", 32'(cpu_rdata), 32'hCCCC);
        tick();

        // Out-of-range debug read, then write
        cpu_req = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'd64;
        settle();
        check("oor_rd_gnt", 32'(dbg_gnt), 32'd1);
        check("oor_rd_we", 32'(mem_we), 32'd0);
        tick();
        dbg_req = 0;
        settle();
        check("oor_rd_err", 32'(dbg_err), 32'd1);
        check("oor_rd_rvalid", 32'(dbg_rvalid), 32'd0);
        check("oor_rd_rdata", 32'(dbg_rdata), 32'h1007);
        tick();
        check("oor_err_pulse", 32'(dbg_err), 32'd0);
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'd64; dbg_wdata = 16'h5555;
        settle();
        check("oor_wr_gnt", 32'(dbg_gnt), 32'd1);
        check("oor_wr_we", 32'(mem_we), 32'd0);
        tick();
        dbg_req = 0; dbg_we = 0;
        settle();
        check("oor_wr_err", 32'(dbg_err), 32'd1);
        check("oor_mem0", 32'(mem[0]), 32'h1000);
        check("oor_cnt", 32'(dut.starve_cnt), 32'd0);
        tick();

        // Reset while locked with a read pending
        dbg_req = 1; dbg_we = 0; dbg_lock = 1; dbg_addr = 16'd11;
        settle();
        check("rl_gnt", 32'(dbg_gnt), 32'd1);
        tick();
        dbg_addr = 16'd12;
        settle();
        check("rl_state", 32'(dut.state_q), 32'(S_LOCK));
        check("rl_rvalid", 32'(dbg_rvalid), 32'd1);
        check("rl_rdata", 32'(dbg_rdata), 32'hBBBB);
        rst = 0;
        settle();
        check("rl_gnt_forced", 32'(dbg_gnt), 32'd0);
        tick();
        rst = 1; dbg_req = 0; dbg_lock = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'd12;
        settle();
        check("rl_post_state", 32'(dut.state_q), 32'(S_CPU));
        check("rl_post_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rl_post_cnt", 32'(dut.starve_cnt), 32'd0);
        check("rl_post_stall", 32'(cpu_stall), 32'd0);
        check("rl_post_rdata", 32'(cpu_rdata), 32'hCCCC);
        tick();

        // Idle
        cpu_req = 0;
        settle();
        for (int c = 0; c < 10; c++) begin
            check("idle_we", 32'(mem_we), 32'd0);
            check("idle_stall", 32'(cpu_stall), 32'd0);
            check("idle_cnt", 32'(dut.starve_cnt), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
